// File: rtl/cdiv.sv
// cdiv: sequential Q1.15 complex divider Y = A / B with constant latency
// Ports: clk, rst_n (async, active low); valid_i/ready_o accept A_real, A_imag,
// B_real, B_imag; valid_o/ready_i present Y_real, Y_imag, sat_o (saturated),
// dz_o (divisor zero).
module cdiv #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] A_real,
    input  logic [DATA_WIDTH-1:0] A_imag,
    input  logic [DATA_WIDTH-1:0] B_real,
    input  logic [DATA_WIDTH-1:0] B_imag,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] Y_real,
    output logic [DATA_WIDTH-1:0] Y_imag,
    output logic                  sat_o,
    output logic                  dz_o
);
    localparam int W  = DATA_WIDTH;
    localparam int P  = 2 * W;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t              r_state;
    logic signed [W-1:0] r_ar, r_ai, r_br, r_bi;
    logic [P-1:0]        r_rem_re, r_rem_im, r_den;
    logic [W-2:0]        r_q_re, r_q_im;
    logic                r_neg_re, r_neg_im, r_sat_re, r_sat_im, r_dz;
    logic [CW-1:0]       r_cnt;

    logic signed [P-1:0] w_p_rr, w_p_ii, w_p_ir, w_p_ri, w_p_bb, w_p_cc;
    logic signed [P:0]   w_num_re, w_num_im;
    logic [P:0]          w_mag_re, w_mag_im, w_sh_re, w_sh_im;
    logic [P-1:0]        w_den, w_nrem_re, w_nrem_im;
    logic                w_ge_re, w_ge_im;
    logic [W-1:0]        w_qe_re, w_qe_im, w_y_re, w_y_im;

    assign ready_o = (r_state == IDLE);

    // Products are widened before multiplying so no bits are lost
    assign w_p_rr   = P'(r_ar) * P'(r_br);
    assign w_p_ii   = P'(r_ai) * P'(r_bi);
    assign w_p_ir   = P'(r_ai) * P'(r_br);
    assign w_p_ri   = P'(r_ar) * P'(r_bi);
    assign w_p_bb   = P'(r_br) * P'(r_br);
    assign w_p_cc   = P'(r_bi) * P'(r_bi);
    assign w_num_re = {w_p_rr[P-1], w_p_rr} + {w_p_ii[P-1], w_p_ii};
    assign w_num_im = {w_p_ir[P-1], w_p_ir} - {w_p_ri[P-1], w_p_ri};
    assign w_den    = w_p_bb + w_p_cc;
    assign w_mag_re = w_num_re[P] ? -w_num_re : w_num_re;
    assign w_mag_im = w_num_im[P] ? -w_num_im : w_num_im;

    // One restoring step per component; remainder stays below den so the shift never overflows
    assign w_sh_re   = {r_rem_re, 1'b0};
    assign w_sh_im   = {r_rem_im, 1'b0};
    assign w_ge_re   = w_sh_re >= {1'b0, r_den};
    assign w_ge_im   = w_sh_im >= {1'b0, r_den};
    assign w_nrem_re = w_ge_re ? P'(w_sh_re - {1'b0, r_den}) : w_sh_re[P-1:0];
    assign w_nrem_im = w_ge_im ? P'(w_sh_im - {1'b0, r_den}) : w_sh_im[P-1:0];

    // Saturated value is 0x7FFF for positive numerators, 0x8000 for negative
    assign w_qe_re = {1'b0, r_q_re};
    assign w_qe_im = {1'b0, r_q_im};
    assign w_y_re  = r_sat_re ? {r_neg_re, {(W-1){~r_neg_re}}} : (r_neg_re ? -w_qe_re : w_qe_re);
    assign w_y_im  = r_sat_im ? {r_neg_im, {(W-1){~r_neg_im}}} : (r_neg_im ? -w_qe_im : w_qe_im);

    // The counter starts at W-1: W-1 iteration cycles, then one cycle to register the signed result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ar     <= '0;
            r_ai     <= '0;
            r_br     <= '0;
            r_bi     <= '0;
            r_rem_re <= '0;
            r_rem_im <= '0;
            r_den    <= '0;
            r_q_re   <= '0;
            r_q_im   <= '0;
            r_neg_re <= 1'b0;
            r_neg_im <= 1'b0;
            r_sat_re <= 1'b0;
            r_sat_im <= 1'b0;
            r_dz     <= 1'b0;
            r_cnt    <= '0;
            valid_o  <= 1'b0;
            Y_real   <= '0;
            Y_imag   <= '0;
            sat_o    <= 1'b0;
            dz_o     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (valid_i) begin
                    r_ar    <= A_real;
                    r_ai    <= A_imag;
                    r_br    <= B_real;
                    r_bi    <= B_imag;
                    r_state <= MUL;
                end
                MUL: begin
                    r_rem_re <= w_mag_re[P-1:0];
                    r_rem_im <= w_mag_im[P-1:0];
                    r_den    <= w_den;
                    r_neg_re <= w_num_re[P];
                    r_neg_im <= w_num_im[P];
                    r_sat_re <= w_mag_re >= {1'b0, w_den};
                    r_sat_im <= w_mag_im >= {1'b0, w_den};
                    r_dz     <= w_den == '0;
                    r_q_re   <= '0;
                    r_q_im   <= '0;
                    r_cnt    <= CW'(W - 1);
                    r_state  <= DIV;
                end
                DIV: if (r_cnt != '0) begin
                    r_rem_re <= w_nrem_re;
                    r_rem_im <= w_nrem_im;
                    r_q_re   <= {r_q_re[W-3:0], w_ge_re};
                    r_q_im   <= {r_q_im[W-3:0], w_ge_im};
                    r_cnt    <= r_cnt - 1'b1;
                end else begin
                    Y_real  <= w_y_re;
                    Y_imag  <= w_y_im;
                    sat_o   <= r_sat_re | r_sat_im;
                    dz_o    <= r_dz;
                    valid_o <= 1'b1;
                    r_state <= DONE;
                end
                DONE: if (ready_i) begin
                    valid_o <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cdiv.sv
// tb_cdiv: randomized scoreboard bench for cdiv against an arithmetic reference
module tb_cdiv;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [15:0] A_real = '0, A_imag = '0, B_real = '0, B_imag = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [15:0] Y_real, Y_imag;
    logic        sat_o, dz_o;

    cdiv #(.DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .A_real(A_real), .A_imag(A_imag), .B_real(B_real), .B_imag(B_imag),
        .valid_o(valid_o), .ready_i(ready_i), .Y_real(Y_real), .Y_imag(Y_imag),
        .sat_o(sat_o), .dz_o(dz_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] yr;
        logic [15:0] yi;
        logic        sat;
        logic        dz;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   mode = 0;
    logic pv = 1'b0;
    logic exp_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] comp(input longint n, input longint d);
        longint mag = n < 0 ? -n : n;
        longint qq;
        if (mag >= d) return n < 0 ? 16'h8000 : 16'h7FFF;
        qq = (mag * 32768) / d;
        return n < 0 ? 16'(-qq) : 16'(qq);
    endfunction

    function automatic exp_t model(input logic [15:0] ar, ai, br, bi);
        exp_t e;
        longint a_r = longint'($signed(ar));
        longint a_i = longint'($signed(ai));
        longint b_r = longint'($signed(br));
        longint b_i = longint'($signed(bi));
        longint nr = a_r * b_r + a_i * b_i;
        longint ni = a_i * b_r - a_r * b_i;
        longint den = b_r * b_r + b_i * b_i;
        e.yr  = comp(nr, den);
        e.yi  = comp(ni, den);
        e.sat = ((nr < 0 ? -nr : nr) >= den) || ((ni < 0 ? -ni : ni) >= den);
        e.dz  = den == 0;
        e.acc = 0;
        return e;
    endfunction

    task automatic send(input logic [15:0] ar, ai, br, bi);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            chk("accept_timeout", 32'(ready_o), 32'd1);
            return;
        end
        A_real = ar; A_imag = ai; B_real = br; B_imag = bi;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        e = model(ar, ai, br, bi);
        e.acc = cyc;
        q.push_back(e);
        valid_i = 1'b0;
        A_real = 16'($urandom); A_imag = 16'($urandom);
        B_real = 16'($urandom); B_imag = 16'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        ready_i = mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : ($urandom_range(3) != 0);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pv <= 1'b0;
            exp_rdy <= 1'b0;
        end else begin
            if (exp_rdy) begin
                chk("ready_after_handshake", 32'(ready_o), 32'd1);
                chk("valid_dropped", 32'(valid_o), 32'd0);
            end
            exp_rdy <= 1'b0;
            if (valid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 32'(valid_o), 32'd0);
                end else begin
                    if (!pv) chk("latency", 32'(cyc - q[0].acc), 32'd17);
                    chk("Y_real", 32'(Y_real), 32'(q[0].yr));
                    chk("Y_imag", 32'(Y_imag), 32'(q[0].yi));
                    chk("sat_o", 32'(sat_o), 32'(q[0].sat));
                    chk("dz_o", 32'(dz_o), 32'(q[0].dz));
                    chk("ready_o_busy", 32'(ready_o), 32'd0);
                    if (ready_i) begin
                        void'(q.pop_front());
                        exp_rdy <= 1'b1;
                    end
                end
            end
            pv <= valid_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd1);
        chk("rst_Y", {Y_real, Y_imag}, 32'd0);
        chk("rst_flags", {30'd0, sat_o, dz_o}, 32'd0);
        rst_n = 1'b1;
        mode = 0;
        send(16'h2000, 16'h0000, 16'h4000, 16'h0000);
        send(16'h2000, 16'h0000, 16'h0000, 16'h4000);
        send(16'h1000, 16'h0000, 16'h3000, 16'h0000);
        send(16'hF000, 16'h0000, 16'h3000, 16'h0000);
        send(16'h4000, 16'h0000, 16'h2000, 16'h0000);
        send(16'hE000, 16'h0000, 16'h2000, 16'h0000);
        send(16'h1234, 16'h5678, 16'h0000, 16'h0000);
        send(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        send(16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF);
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ar, ai, br, bi;
            ar = 16'($urandom); ai = 16'($urandom);
            br = 16'($urandom); bi = 16'($urandom);
            if (i % 3 == 0) begin
                ar = 16'($signed(ar) >>> 3);
                ai = 16'($signed(ai) >>> 3);
            end
            send(ar, ai, br, bi);
        end
        drain();
        mode = 1;
        send(16'h0C00, 16'hF400, 16'h2000, 16'h1000);
        begin
            int n = 0;
            while (!valid_o && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("bp_valid_timeout", 32'(valid_o), 32'd1);
        end
        repeat (5) begin
            @(negedge clk);
            valid_i = 1'b1;
            A_real = 16'($urandom); A_imag = 16'($urandom);
            B_real = 16'($urandom); B_imag = 16'($urandom);
        end
        @(negedge clk);
        valid_i = 1'b0;
        mode = 2;
        drain();
        send(16'h1111, 16'h2222, 16'h0000, 16'h0000);
        drain();
        send(16'h3000, 16'h1000, 16'h4000, 16'h0000);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_valid_o", 32'(valid_o), 32'd0);
        chk("midrst_Y", {Y_real, Y_imag}, 32'd0);
        chk("midrst_flags", {30'd0, sat_o, dz_o}, 32'd0);
        chk("midrst_ready_o", 32'(ready_o), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        send(16'h0800, 16'h0000, 16'h4000, 16'h0000);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
